// File: rtl/i4001_rom_port.sv
// i4001_rom_port: one 4001 ROM/IO chip attached to the i4004 4-bit bus.
// It follows the 8-phase bus cycle by watching the core's clk2 and SYNC.
// It latches the fetch address and returns the opcode byte from an
// external byte store when this chip is addressed.
// It also implements the 4-bit I/O port: SRC selection, WRR and RDR.
module i4001_rom_port #(
  parameter logic [3:0] CHIP_ID = 4'h0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk1_i,
  input  logic       clk2_i,
  input  logic       sync_i,
  input  logic       cmrom_i,
  input  logic [3:0] data_i,
  output logic [3:0] data_o,
  output logic       data_oe,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_data,
  input  logic [3:0] io_in,
  output logic [3:0] io_out
);

  typedef enum logic [2:0] {
    PH_A1 = 3'd0, PH_A2 = 3'd1, PH_A3 = 3'd2, PH_M1 = 3'd3,
    PH_M2 = 3'd4, PH_X1 = 3'd5, PH_X2 = 3'd6, PH_X3 = 3'd7
  } phase_t;

  phase_t     ph, ph_next;
  logic       clk2_q;
  logic       pt;          // one-clk tick at the falling edge of clk2
  logic       locked;      // set by the first SYNC after reset
  logic       latch_en;    // end-of-phase strobe, only once locked
  logic [7:0] addr;
  logic       sel;         // this chip owns the current fetch
  logic       cap_d1, cap_d2;
  logic [7:0] opbyte;
  logic [3:0] opr, opa;
  logic       io_pend;     // current instruction is an I/O op with CM-ROM
  logic       src_sel;     // last SRC addressed this chip
  logic       io_sel;
  logic       unused_ok;

  assign pt       = clk2_q & ~clk2_i;
  assign latch_en = pt & locked;
  assign io_sel   = io_pend & src_sel;

  // clk1 is monitored only, and addr[7:4] is kept for visibility; both sink here.
  assign unused_ok = clk1_i ^ (^addr[7:4]);

  // Register clk2 so its falling edge can be detected in the clk domain.
  // NOTE: every register, data latches included, resets to a defined value so
  // the bus and the port come up quiet and a mid-cycle reset is clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) clk2_q <= 1'b0;
    else        clk2_q <= clk2_i;
  end

  // Phase state register; the first SYNC tick locks the tracker.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph     <= PH_A1;
      locked <= 1'b0;
    end else if (pt) begin
      ph <= ph_next;
      if (sync_i) locked <= 1'b1;
    end
  end

  // Next phase: SYNC always restarts at A1 (also resyncs an early SYNC).
  // NOTE: each combinational output gets a default first so no latch is inferred.
  always_comb begin
    ph_next = ph;
    if (sync_i) ph_next = PH_A1;
    else        ph_next = phase_t'(ph + 3'd1);
  end

  // Address latches, chip select and delayed capture of the store byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr     <= 8'h00;
      rom_addr <= 8'h00;
      sel      <= 1'b0;
      cap_d1   <= 1'b0;
      cap_d2   <= 1'b0;
      opbyte   <= 8'h00;
    end else begin
      cap_d1 <= latch_en && (ph == PH_A2);
      cap_d2 <= cap_d1;
      if (cap_d2) opbyte <= rom_data;
      if (latch_en) begin
        case (ph)
          PH_A1: addr[3:0] <= data_i;
          PH_A2: begin
            addr[7:4] <= data_i;
            rom_addr  <= {data_i, addr[3:0]};
          end
          PH_A3: sel <= cmrom_i & (data_i == CHIP_ID);
          default: ;
        endcase
      end
    end
  end

  // Instruction nibbles, I/O pending flag, SRC selection and the output port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opr     <= 4'h0;
      opa     <= 4'h0;
      io_pend <= 1'b0;
      src_sel <= 1'b0;
      io_out  <= 4'h0;
    end else if (latch_en) begin
      case (ph)
        PH_M1: opr <= data_i;
        PH_M2: begin
          opa     <= data_i;
          io_pend <= cmrom_i & (opr == 4'hE);
        end
        PH_X2: begin
          if (cmrom_i && !io_pend) src_sel <= (data_i == CHIP_ID);
          if (io_sel && (opa == 4'h0)) io_out <= data_i;
        end
        PH_X3: io_pend <= 1'b0;
        default: ;
      endcase
    end
  end

  // Bus drive: opcode nibbles in M1/M2 when selected, port input on RDR in X2.
  always_comb begin
    data_oe = 1'b0;
    data_o  = 4'h0;
    if (locked) begin
      case (ph)
        PH_M1: if (sel) begin
          data_oe = 1'b1;
          data_o  = opbyte[7:4];
        end
        PH_M2: if (sel) begin
          data_oe = 1'b1;
          data_o  = opbyte[3:0];
        end
        PH_X2: if (io_sel && (opa == 4'hA)) begin
          data_oe = 1'b1;
          data_o  = io_in;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i4001_rom_port.sv
// Testbench for i4001_rom_port: drives bus cycles as the i4004 core would,
// models the external byte store, and scoreboards the chip's bus drive.
module tb_i4001_rom_port;

  logic       clk, rst_n;
  logic       clk1_i, clk2_i, sync_i, cmrom_i;
  logic [3:0] data_i, data_o, io_in, io_out;
  logic       data_oe;
  logic [7:0] rom_addr, rom_data;

  logic [7:0] store [256];

  typedef struct {
    string      tag;
    logic       oe;
    logic [3:0] dat;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  i4001_rom_port #(.CHIP_ID(4'h2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clk1_i   (clk1_i),
    .clk2_i   (clk2_i),
    .sync_i   (sync_i),
    .cmrom_i  (cmrom_i),
    .data_i   (data_i),
    .data_o   (data_o),
    .data_oe  (data_oe),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .io_in    (io_in),
    .io_out   (io_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External byte store: registered read, valid one clk after the address.
  always @(posedge clk) rom_data <= store[rom_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Pop one expected bus state and compare it with what the chip drives.
  task automatic sample();
    exp_t e;
    e = exp_q.pop_front();
    check({e.tag, "_oe"}, data_oe, e.oe);
    if (e.oe) check({e.tag, "_do"}, data_o, e.dat);
  endtask

  // One bus phase: clk2 high 4 clks then low 4 clks; the falling edge ends it.
  // Called at a negedge; the bus is sampled early and late inside the phase.
  task automatic bus_phase(input logic [3:0] d, input logic cm, input logic sy,
                           input logic eoe, input logic [3:0] edat, input string tag);
    exp_t e;
    data_i  = d;
    cmrom_i = cm;
    sync_i  = sy;
    clk2_i  = 1'b1;
    clk1_i  = 1'b0;
    e.oe  = eoe;
    e.dat = edat;
    e.tag = {tag, "_early"};
    exp_q.push_back(e);
    e.tag = {tag, "_late"};
    exp_q.push_back(e);
    @(posedge clk); @(negedge clk);
    sample();
    repeat (3) @(posedge clk);
    @(negedge clk);
    sample();
    clk2_i = 1'b0;
    clk1_i = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
  endtask

  // Full 8-phase cycle. nib holds nibbles X3..A1 (A1 in bits 3:0);
  // cm/eoe hold one bit per phase; sy raises SYNC in X3.
  task automatic run_cycle(input string tag, input logic [31:0] nib, input logic [7:0] cm,
                           input logic sy, input logic [7:0] eoe, input logic [31:0] edat);
    for (int p = 0; p < 8; p++)
      bus_phase(nib[4*p +: 4], cm[p], sy && (p == 7), eoe[p], edat[4*p +: 4],
                $sformatf("%s_p%0d", tag, p));
  endtask

  // Expected M1/M2 nibbles for a fetched byte, placed in the edat layout.
  function automatic logic [31:0] fetch_exp(input logic [7:0] b);
    return {12'h000, b[3:0], b[7:4], 12'h000};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish within its time limit");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) store[i] = 8'(i * 7 + 3);
    store[8'h35] = 8'hD7;

    rst_n = 1'b0; clk1_i = 1'b0; clk2_i = 1'b0; sync_i = 1'b0;
    cmrom_i = 1'b0; data_i = 4'h0; io_in = 4'h0;
    repeat (3) @(negedge clk);
    check("rst_oe", data_oe, 1'b0);
    check("rst_do", data_o, 4'h0);
    check("rst_io_out", io_out, 4'h0);
    check("rst_rom_addr", rom_addr, 8'h00);
    check("rst_ph", dut.ph, 3'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Misaligned idle phases so the SYNC tick differs from a plain wrap.
    for (int i = 0; i < 3; i++) bus_phase(4'h0, 1'b0, 1'b0, 1'b0, 4'h0, "pre");

    // Unlocked: selecting fetch with CM-ROM high must not drive or latch.
    run_cycle("unlk1", 32'h0007D235, 8'hFF, 1'b0, 8'h00, 32'h0);
    check("unlk_rom_addr", rom_addr, 8'h00);
    run_cycle("unlk2", 32'h0007D235, 8'hFF, 1'b1, 8'h00, 32'h0);
    check("lock_ph", dut.ph, 3'd0);
    check("lock_locked", dut.locked, 1'b1);

    // Deselect by chip number: no drive, address still latched.
    run_cycle("desel_a3", 32'h00000435, 8'h04, 1'b1, 8'h00, 32'h0);
    check("desel_a3_rom_addr", rom_addr, 8'h35);
    run_cycle("fetch_c1", 32'h000002C1, 8'h04, 1'b1, 8'h18, fetch_exp(store[8'hC1]));
    check("fetch_c1_rom_addr", rom_addr, 8'hC1);
    run_cycle("fetch_35", 32'h0007D235, 8'h04, 1'b1, 8'h18, 32'h0007D000);
    check("fetch_35_rom_addr", rom_addr, 8'h35);
    // Deselect by CM-ROM low.
    run_cycle("desel_cm", 32'h0000026A, 8'h00, 1'b1, 8'h00, 32'h0);
    check("desel_cm_rom_addr", rom_addr, 8'h6A);

    // SRC chip 2, then WRR writes 9.
    run_cycle("src2", 32'h02012000, 8'h44, 1'b1, 8'h00, 32'h0);
    run_cycle("wrr9", 32'h0900E000, 8'h14, 1'b1, 8'h00, 32'h0);
    check("wrr9_io_out", io_out, 4'h9);
    // SRC chip 3 deselects the port; WRR 5 must not land.
    run_cycle("src3", 32'h03012000, 8'h44, 1'b1, 8'h00, 32'h0);
    run_cycle("wrr5", 32'h0500E000, 8'h14, 1'b1, 8'h00, 32'h0);
    check("wrr5_io_out", io_out, 4'h9);

    // SRC chip 2 again, then RDR returns io_in in X2 only.
    run_cycle("src2b", 32'h02012000, 8'h44, 1'b1, 8'h00, 32'h0);
    io_in = 4'h6;
    run_cycle("rdr", 32'h000AE000, 8'h14, 1'b1, 8'h40, 32'h06000000);
    check("rdr_io_out", io_out, 4'h9);

    // Early SYNC in M2: the chip still drives M2, then restarts at A1.
    bus_phase(4'h5, 1'b0, 1'b0, 1'b0, 4'h0, "early_a1");
    bus_phase(4'h3, 1'b0, 1'b0, 1'b0, 4'h0, "early_a2");
    bus_phase(4'h2, 1'b1, 1'b0, 1'b0, 4'h0, "early_a3");
    bus_phase(4'hD, 1'b0, 1'b0, 1'b1, 4'hD, "early_m1");
    bus_phase(4'h7, 1'b0, 1'b1, 1'b1, 4'h7, "early_m2");
    check("early_sync_ph", dut.ph, 3'd0);
    run_cycle("resync", 32'h000002C1, 8'h04, 1'b1, 8'h18, fetch_exp(store[8'hC1]));

    // Reset in the middle of a driven M1.
    bus_phase(4'h5, 1'b0, 1'b0, 1'b0, 4'h0, "mrst_a1");
    bus_phase(4'h3, 1'b0, 1'b0, 1'b0, 4'h0, "mrst_a2");
    bus_phase(4'h2, 1'b1, 1'b0, 1'b0, 4'h0, "mrst_a3");
    data_i = 4'hD; cmrom_i = 1'b0; sync_i = 1'b0; clk2_i = 1'b1;
    @(posedge clk); @(negedge clk);
    check("mrst_pre_oe", data_oe, 1'b1);
    check("mrst_pre_do", data_o, 4'hD);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_oe", data_oe, 1'b0);
    check("mrst_io_out", io_out, 4'h0);
    check("mrst_rom_addr", rom_addr, 8'h00);
    clk2_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_cycle("post_rst", 32'h0007D235, 8'h04, 1'b0, 8'h00, 32'h0);
    run_cycle("relock", 32'h0007D235, 8'h04, 1'b1, 8'h00, 32'h0);
    run_cycle("after_relock", 32'h0007D235, 8'h04, 1'b1, 8'h18, 32'h0007D000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
